boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Serial program loader upstream of cpu. Takes a byte stream from the UART receiver and
//  packs it into 32-bit words written to ram port A. Holds cpu in reset (cpu_rst) until a
//  complete image passes checksum, then releases it.
//  While cpu_rst=1, ram port A is muxed to this block; the mux sits outside this block.
// PARAMETERS
//  ADDR_W     9    ram word-address width (matches ram addr_a)
//  MAX_WORDS  512  largest accepted image, in words; must be <= 2**ADDR_W
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, ACTIVE-LOW reset
//  rx_valid   in   1       one-cycle strobe: rx_data holds a new byte
//  rx_data    in   8       received byte
//  ram_we     out  4       byte write enables to ram port A
//  ram_addr   out  ADDR_W  word address to ram port A
//  ram_wdata  out  32      write data to ram port A
//  cpu_rst    out  1       active-high reset to cpu; 1 until image accepted
//  done       out  1       image loaded and checksum good (sticky)
//  err        out  1       oversize image or bad checksum (sticky)
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state=HDR_HI, ram_we=0, ram_addr=0, ram_wdata=0,
//   cpu_rst=1, done=0, err=0, byte_cnt=0, word_cnt=0, csum=0. Reset wins over rx_valid.
//   A reset mid-load abandons the load. Already-written ram words are not cleared.
//  Stream format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then 4*N data bytes.
//   Each word is sent MSB first. A final checksum byte follows: XOR of all 4*N data bytes.
//  Bytes are consumed only on cycles with rx_valid=1. No backpressure.
//   rx_valid is ignored in RUN and ERROR.
//  FSM:
//   HDR_HI: on byte, cnt[15:8]<=byte -> HDR_LO
//   HDR_LO: on byte, cnt[7:0]<=byte
//    if N>MAX_WORDS -> ERROR
//    else if N==0 -> CSUM
//    else -> DATA
//   DATA: on byte, shift wdata<={wdata[23:0],byte} and csum^=byte, byte_cnt++ (mod 4).
//    On the 4th byte: ram_we=4'hF for exactly the next cycle, with the assembled word,
//    at ram_addr=word_cnt. Then word_cnt++.
//    After word N-1 is written -> CSUM.
//   CSUM: on byte:
//    if byte==csum -> RUN
//    else -> ERROR
//   RUN: cpu_rst=0 and done=1 from the cycle after the checksum byte. Terminal until reset.
//   ERROR: err=1, cpu_rst stays 1. Terminal until reset.
//  Latency: the ram write occurs 1 cycle after the 4th byte's rx_valid.
//   cpu_rst falls 1 cycle after the good checksum byte.
//  ram_we is 0 in every cycle except write cycles. ram_addr/ram_wdata hold their last value.
//  N==MAX_WORDS is legal: the last write goes to address MAX_WORDS-1.
//   word_cnt never wraps.
//  Back-to-back rx_valid on consecutive cycles is supported in all states.
// TESTING
//  1. N=1, bytes 00 01 DE AD BE EF, then 0x22 (csum)
//     -> one write: addr 0, data 0xDEADBEEF, we=F
//     -> cpu_rst 1->0 and done=1 one cycle after the checksum byte.
//  2. N=2, words 0x11223344 and 0xA5A5A5A5, checksum byte wrong (0x00)
//     -> writes to addr 0 and addr 1; err=1, cpu_rst stays 1, done=0.
//  3. Header 02 01 (N=513) with MAX_WORDS=512 -> err=1 right after CNT_LO, no writes.
//  4. N=0, bytes 00 00 00 -> no writes, done=1, cpu_rst=0.
//  5. N=512 with consecutive rx_valid every cycle
//     -> 512 writes at addr 0..511 in order, correct csum -> done=1.
//  6. rst=0 after 2 data bytes of word 0, then restart with a valid N=1 image
//     -> only the new word is written at addr 0; bytes during RUN cause no writes.

Source files
------------

// File: rtl/boot_loader_if.sv
// Byte-stream input and ram port A / cpu-control outputs of the boot loader.
// The master drives the UART byte strobe. The slave, boot_loader, drives ram and cpu control.
interface boot_loader_if #(
  parameter int ADDR_W = 9
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    output rx_valid, rx_data,
    input  ram_we, ram_addr, ram_wdata, cpu_rst, done, err
  );

  modport slave (
    input  rx_valid, rx_data,
    output ram_we, ram_addr, ram_wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/boot_loader.sv
// Serial program loader. It packs a counted byte stream into 32-bit ram words and checks
// an XOR checksum. The cpu stays in reset until a complete image has been accepted.
module boot_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 512
) (
  input logic          clk,
  input logic          rst,
  boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    RUN,
    ERROR
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic [23:0] shift;
  logic [15:0] hdr_n;

  assign hdr_n = {cnt[15:8], bus.rx_data};

  // NOTE: all state is updated with non-blocking assignments, so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= HDR_HI;
      cnt           <= '0;
      word_cnt      <= '0;
      byte_cnt      <= '0;
      csum          <= '0;
      shift         <= '0;
      bus.ram_we    <= '0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.cpu_rst   <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      // NOTE: default the write strobe every cycle so that it is a single-cycle pulse.
      bus.ram_we <= '0;
      if (bus.rx_valid) begin
        unique case (state)
          HDR_HI: begin
            cnt[15:8] <= bus.rx_data;
            state     <= HDR_LO;
          end
          HDR_LO: begin
            cnt[7:0] <= bus.rx_data;
            if (hdr_n > MAX_N) begin
              state   <= ERROR;
              bus.err <= 1'b1;
            end else if (hdr_n == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            shift    <= {shift[15:0], bus.rx_data};
            csum     <= csum ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.ram_we    <= 4'hF;
              bus.ram_wdata <= {shift, bus.rx_data};
              bus.ram_addr  <= word_cnt[ADDR_W-1:0];
              word_cnt      <= word_cnt + 16'd1;
              if (word_cnt + 16'd1 == cnt) state <= CSUM;
            end
          end
          CSUM: begin
            if (bus.rx_data == csum) begin
              state       <= RUN;
              bus.cpu_rst <= 1'b0;
              bus.done    <= 1'b1;
            end else begin
              state   <= ERROR;
              bus.err <= 1'b1;
            end
          end
          default: ; // RUN and ERROR are terminal until reset
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader. It compares against an image-level reference model
// (an expected word list, the stream checksum, and the accept/reject outcome).
module tb_boot_loader;
  localparam int ADDR_W    = 9;
  localparam int MAX_WORDS = 512;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        we;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  wr_t  wr_q[$];

  boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Capture every ram write, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ram_we !== 4'h0) begin
      wr_t w;
      w.addr = bus.ram_addr;
      w.data = bus.ram_wdata;
      w.we   = bus.ram_we;
      wr_q.push_back(w);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int cycles);
    bus.rx_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // Present one byte for one clock. The task returns at the negedge after that byte is consumed.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wr_q.delete();
  endtask

  task automatic check_reset_state(input string name);
    tests_run++;
    if (bus.ram_we !== 4'h0 || bus.ram_addr !== '0 || bus.ram_wdata !== 32'h0 ||
        bus.cpu_rst !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: we=%h addr=%0d wdata=%h cpu_rst=%b done=%b err=%b, expected 0 0 0 1 0 0",
               name, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_rst, bus.done, bus.err);
    end
  endtask

  // Send a complete image and check the outcome against the model.
  // csum_sel: -1 sends the correct checksum, -2 sends a corrupted one, and 0..255 sends that exact byte.
  task automatic run_image(input string name, input int n, input logic [31:0] w[$],
                           input int csum_sel, input bit gaps);
    logic [7:0] x;
    logic [7:0] sent;
    bit         good;
    logic [15:0] n16;
    x   = 8'h00;
    n16 = 16'(n);
    wr_q.delete();
    send_byte(n16[15:8], gaps);
    send_byte(n16[7:0], gaps);
    if (n > MAX_WORDS) begin
      tests_run++;
      if (bus.err !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s oversize: err=%b cpu_rst=%b done=%b, expected 1 1 0",
                 name, bus.err, bus.cpu_rst, bus.done);
      end
      repeat (8) send_byte(8'($urandom), gaps);
      idle(2);
      tests_run++;
      if (wr_q.size() != 0) begin
        tests_failed++;
        $display("FAIL %s oversize writes: got %0d, expected 0", name, wr_q.size());
      end
      return;
    end
    foreach (w[i]) begin
      for (int b = 3; b >= 0; b--) begin
        logic [7:0] byte_v;
        byte_v = w[i][8*b +: 8];
        x ^= byte_v;
        send_byte(byte_v, gaps);
      end
    end
    if (csum_sel == -1)      sent = x;
    else if (csum_sel == -2) sent = x ^ 8'($urandom_range(1, 255));
    else                     sent = 8'(csum_sel);
    good = (sent == x);
    if (gaps) idle($urandom_range(0, 2));
    tests_run++;
    if (bus.cpu_rst !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s before csum: cpu_rst=%b done=%b err=%b, expected 1 0 0",
               name, bus.cpu_rst, bus.done, bus.err);
    end
    send_byte(sent, 1'b0);
    tests_run++;
    if (bus.done !== good || bus.err !== !good || bus.cpu_rst !== !good) begin
      tests_failed++;
      $display("FAIL %s after csum: done=%b err=%b cpu_rst=%b, expected %b %b %b",
               name, bus.done, bus.err, bus.cpu_rst, good, !good, !good);
    end
    idle(2);
    tests_run++;
    if (wr_q.size() != n) begin
      tests_failed++;
      $display("FAIL %s write count: got %0d, expected %0d", name, wr_q.size(), n);
    end else begin
      int bad;
      bad = 0;
      foreach (wr_q[i]) begin
        if (wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== w[i] || wr_q[i].we !== 4'hF) begin
          if (bad == 0)
            $display("FAIL %s write %0d: addr=%0d data=%h we=%h, expected %0d %h F",
                     name, i, wr_q[i].addr, wr_q[i].data, wr_q[i].we, i, w[i]);
          bad++;
        end
      end
      if (bad != 0) tests_failed++;
    end
    if (n > 0) begin
      tests_run++;
      if (bus.ram_addr !== ADDR_W'(n - 1) || bus.ram_wdata !== w[n-1]) begin
        tests_failed++;
        $display("FAIL %s hold: addr=%0d wdata=%h, expected %0d %h",
                 name, bus.ram_addr, bus.ram_wdata, n - 1, w[n-1]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_state("reset");
  endtask

  task automatic test_single_word();
    logic [31:0] w[$];
    do_reset();
    w = '{32'hDEADBEEF};
    run_image("single_word", 1, w, 8'h22, 1'b0);
  endtask

  task automatic test_bad_csum();
    logic [31:0] w[$];
    do_reset();
    w = '{32'h11223344, 32'hA5A5A5A5};
    run_image("bad_csum", 2, w, 8'h00, 1'b0);
    repeat (4) send_byte(8'($urandom), 1'b0);
    idle(2);
    tests_run++;
    if (wr_q.size() != 2 || bus.err !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_csum terminal: writes=%0d err=%b done=%b, expected 2 1 0",
               wr_q.size(), bus.err, bus.done);
    end
  endtask

  task automatic test_oversize();
    logic [31:0] w[$];
    do_reset();
    run_image("oversize", MAX_WORDS + 1, w, -1, 1'b0);
  endtask

  task automatic test_empty();
    logic [31:0] w[$];
    do_reset();
    run_image("empty", 0, w, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back_max();
    logic [31:0] w[$];
    do_reset();
    for (int i = 0; i < MAX_WORDS; i++) w.push_back($urandom);
    run_image("max_b2b", MAX_WORDS, w, -1, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [31:0] w[$];
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    check_reset_state("mid_reset");
    w = '{$urandom};
    run_image("mid_reset_reload", 1, w, -1, 1'b1);
    repeat (8) send_byte(8'($urandom), 1'b0);
    idle(2);
    tests_run++;
    if (wr_q.size() != 1 || bus.done !== 1'b1 || bus.cpu_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_ignores_rx: writes=%0d done=%b cpu_rst=%b, expected 1 1 0",
               wr_q.size(), bus.done, bus.cpu_rst);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] w[$];
      int n;
      do_reset();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_image($sformatf("random%0d", k), n, w, ($urandom_range(0, 1) == 1) ? -1 : -2, 1'b1);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_single_word();
    test_bad_csum();
    test_oversize();
    test_empty();
    test_back_to_back_max();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
